// File: rtl/byte_ser_pkg.sv
// Shared definitions for the byte serializer: FSM encoding, legal parameter
// bounds and the bit counter width helper.
package byte_ser_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } ser_state_t;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;
   localparam int GAP_MIN   = 0;
   localparam int GAP_MAX   = 15;
   localparam int GAP_CNT_W = 4;

   // Enough bits to count 0..width-1.
   function automatic int cnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/byte_serializer_if.sv
// Word-in / bit-out handshake bundle of the byte serializer.
interface byte_serializer_if #(
   parameter int WIDTH = 8
);

   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             x;
   logic             x_valid;
   logic             busy;

   modport master (
      output din,
      output din_valid,
      input  din_ready,
      input  x,
      input  x_valid,
      input  busy
   );

   modport slave (
      input  din,
      input  din_valid,
      output din_ready,
      output x,
      output x_valid,
      output busy
   );

endinterface

// File: rtl/byte_ser_hold.sv
// One-word hold register in front of the shifter; ready depends only on the
// registered full flag so upstream sees no combinational path.
module byte_ser_hold
   import byte_ser_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             load,
   output logic [WIDTH-1:0] hold_data,
   output logic             hold_full,
   output logic             din_ready
);

   logic accept;

   assign din_ready = ~hold_full;
   assign accept    = din_valid & ~hold_full;

   // A load and an accept on the same edge leave the register full with the new word.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_data <= '0;
         hold_full <= 1'b0;
      end else begin
         if (accept) begin
            hold_data <= din;
         end
         hold_full <= accept | (hold_full & ~load);
      end
   end

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial converter: a hold register feeds a shift register that
// emits one bit per cycle, optionally followed by forced idle cycles.
module byte_serializer
   import byte_ser_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter int GAP_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst,
   byte_serializer_if.slave  bus
);

   localparam int                   CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [GAP_CNT_W-1:0] LAST_GAP = GAP_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("byte_serializer: WIDTH out of range");
   end
   if (GAP_CYCLES < GAP_MIN || GAP_CYCLES > GAP_MAX) begin : g_bad_gap
      $error("byte_serializer: GAP_CYCLES out of range");
   end

   ser_state_t           state;
   ser_state_t           state_next;
   logic [WIDTH-1:0]     shift_reg;
   logic [WIDTH-1:0]     shift_next;
   logic [CNT_W-1:0]     bit_cnt;
   logic [GAP_CNT_W-1:0] gap_cnt;
   logic                 load;
   logic                 head;
   logic [WIDTH-1:0]     hold_data;
   logic                 hold_full;

   byte_ser_hold #(
      .WIDTH(WIDTH)
   ) u_hold (
      .clk       (clk),
      .rst       (rst),
      .din       (bus.din),
      .din_valid (bus.din_valid),
      .load      (load),
      .hold_data (hold_data),
      .hold_full (hold_full),
      .din_ready (bus.din_ready)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decision; load pulls the held word into the shifter.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      unique case (state)
         IDLE: begin
            if (hold_full) begin
               load       = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (bit_cnt == LAST_BIT) begin
               if (GAP_CYCLES > 0) begin
                  state_next = GAP;
               end else if (hold_full) begin
                  load       = 1'b1;
                  state_next = SHIFT;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         GAP: begin
            if (gap_cnt == LAST_GAP) begin
               if (hold_full) begin
                  load       = 1'b1;
                  state_next = SHIFT;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign shift_next = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0} : {1'b0, shift_reg[WIDTH-1:1]};
   assign head       = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];

   // Counters wrap back to zero at the end of each word or gap.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
      end else begin
         if (load) begin
            shift_reg <= hold_data;
            bit_cnt   <= '0;
         end else if (state == SHIFT) begin
            shift_reg <= shift_next;
            bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
         end
         if (state == GAP && state_next == GAP) begin
            gap_cnt <= gap_cnt + 1'b1;
         end else begin
            gap_cnt <= '0;
         end
      end
   end

   assign bus.x       = (state == SHIFT) & head;
   assign bus.x_valid = (state == SHIFT);
   assign bus.busy    = (state != IDLE) | hold_full;

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench for byte_serializer: default, gapped and LSB-first instances
// driven with hand-computed words and expected bit streams.
module tb_byte_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  din_s [3];
   logic        dv_s  [3];
   int          n_compared   = 0;
   int          n_mismatched = 0;
   logic [31:0] bits;
   logic [31:0] vpat;
   int          lat;
   int          det_cnt;
   int          stray;

   always #5 clk = ~clk;

   byte_serializer_if #(.WIDTH(8)) bus_a ();
   byte_serializer_if #(.WIDTH(8)) bus_g ();
   byte_serializer_if #(.WIDTH(8)) bus_l ();

   assign bus_a.din       = din_s[0];
   assign bus_a.din_valid = dv_s[0];
   assign bus_g.din       = din_s[1];
   assign bus_g.din_valid = dv_s[1];
   assign bus_l.din       = din_s[2];
   assign bus_l.din_valid = dv_s[2];

   byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut_a (
      .clk (clk), .rst (rst), .bus (bus_a.slave)
   );
   byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) dut_g (
      .clk (clk), .rst (rst), .bus (bus_g.slave)
   );
   byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut_l (
      .clk (clk), .rst (rst), .bus (bus_l.slave)
   );

   function automatic logic get_ready(input int sel);
      case (sel)
         0:       return bus_a.din_ready;
         1:       return bus_g.din_ready;
         default: return bus_l.din_ready;
      endcase
   endfunction

   function automatic logic get_valid(input int sel);
      case (sel)
         0:       return bus_a.x_valid;
         1:       return bus_g.x_valid;
         default: return bus_l.x_valid;
      endcase
   endfunction

   function automatic logic get_x(input int sel);
      case (sel)
         0:       return bus_a.x;
         1:       return bus_g.x;
         default: return bus_l.x;
      endcase
   endfunction

   function automatic logic get_busy(input int sel);
      case (sel)
         0:       return bus_a.busy;
         1:       return bus_g.busy;
         default: return bus_l.busy;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Offer one word at a negedge and hold it until accepted; noisy mode keeps
   // din_valid high and scrambles din while the block is not ready.
   task automatic applyStimulus(input int sel, input logic [7:0] word, input bit noisy);
      bit done;
      done       = 1'b0;
      din_s[sel] = word;
      for (int c = 0; c < 60 && !done; c++) begin
         dv_s[sel] = 1'b1;
         if (get_ready(sel)) begin
            din_s[sel] = word;
            @(posedge clk);
            @(negedge clk);
            checkOutput("ready_low_after_accept", 32'(get_ready(sel)), 32'd0);
            done = 1'b1;
         end else begin
            if (noisy) din_s[sel] = 8'($urandom);
            @(negedge clk);
         end
      end
      if (!noisy) dv_s[sel] = 1'b0;
      checkOutput("accept_in_time", 32'(done), 32'd1);
   endtask

   task automatic collectBits(input int sel, input int n, output logic [31:0] b,
                              output logic [31:0] v, output int latency);
      latency = -1;
      b       = '0;
      v       = '0;
      for (int w = 0; w < 40 && latency < 0; w++) begin
         if (get_valid(sel)) latency = w;
         else @(negedge clk);
      end
      checkOutput("first_bit_seen", 32'(latency >= 0), 32'd1);
      if (latency >= 0) begin
         for (int i = 0; i < n; i++) begin
            b = {b[30:0], get_x(sel)};
            v = {v[30:0], get_valid(sel)};
            @(negedge clk);
         end
      end
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         din_s[i] = 8'h00;
         dv_s[i]  = 1'b0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int s = 0; s < 3; s++) begin
         checkOutput("reset_outputs", {28'd0, get_x(s), get_valid(s), get_busy(s), get_ready(s)}, 32'h1);
      end

      $display("[TB] single word 0x0D on each instance");
      for (int s = 0; s < 3; s++) begin
         fork
            applyStimulus(s, 8'h0D, 1'b0);
            collectBits(s, 8, bits, vpat, lat);
         join
         checkOutput("single_latency", 32'(lat), 32'd2);
         checkOutput("single_bits", bits[7:0], (s == 2) ? 32'hB0 : 32'h0D);
         checkOutput("single_valid", vpat[7:0], 32'hFF);
         checkOutput("single_trailing_valid", 32'(get_valid(s)), 32'd0);
         if (s == 0) begin
            det_cnt = 0;
            for (int i = 0; i <= 4; i++) begin
               if (bits[7-i -: 4] == 4'b1101) det_cnt++;
            end
            checkOutput("detector_hits", 32'(det_cnt), 32'd1);
         end
         repeat (4) @(negedge clk);
         checkOutput("single_idle_busy", 32'(get_busy(s)), 32'd0);
      end

      $display("[TB] back-to-back 0xD0 0xDD, no gap");
      fork
         begin
            applyStimulus(0, 8'hD0, 1'b0);
            applyStimulus(0, 8'hDD, 1'b0);
         end
         collectBits(0, 16, bits, vpat, lat);
      join
      checkOutput("b2b_bits", bits[15:0], 32'hD0DD);
      checkOutput("b2b_valid", vpat[15:0], 32'hFFFF);
      checkOutput("b2b_trailing_valid", 32'(get_valid(0)), 32'd0);
      repeat (4) @(negedge clk);

      $display("[TB] back-to-back 0xD0 0xDD, two gap cycles");
      fork
         begin
            applyStimulus(1, 8'hD0, 1'b0);
            applyStimulus(1, 8'hDD, 1'b0);
         end
         collectBits(1, 18, bits, vpat, lat);
      join
      checkOutput("gap_bits", bits[17:0], 32'(18'b11010000_00_11011101));
      checkOutput("gap_valid", vpat[17:0], 32'(18'b11111111_00_11111111));
      checkOutput("gap_trailing_valid", 32'(get_valid(1)), 32'd0);
      repeat (6) @(negedge clk);

      $display("[TB] reset in the middle of 0xFF with 0xAA held");
      fork
         begin
            applyStimulus(0, 8'hFF, 1'b0);
            applyStimulus(0, 8'hAA, 1'b0);
         end
         collectBits(0, 3, bits, vpat, lat);
      join
      checkOutput("abort_first_bits", bits[2:0], 32'h7);
      checkOutput("abort_busy_before", 32'(get_busy(0)), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_valid", 32'(get_valid(0)), 32'd0);
      checkOutput("abort_ready", 32'(get_ready(0)), 32'd1);
      checkOutput("abort_busy", 32'(get_busy(0)), 32'd0);
      stray = 0;
      repeat (30) begin
         @(negedge clk);
         if (get_valid(0)) stray++;
      end
      checkOutput("abort_stray_bits", 32'(stray), 32'd0);

      $display("[TB] valid held high with noisy din while not ready");
      fork
         begin
            applyStimulus(0, 8'h12, 1'b1);
            applyStimulus(0, 8'h34, 1'b1);
            applyStimulus(0, 8'h56, 1'b1);
            dv_s[0] = 1'b0;
         end
         collectBits(0, 24, bits, vpat, lat);
      join
      checkOutput("noisy_bits", bits[23:0], 32'h123456);
      checkOutput("noisy_valid", vpat[23:0], 32'hFFFFFF);
      checkOutput("noisy_trailing_valid", 32'(get_valid(0)), 32'd0);
      @(negedge clk);
      checkOutput("noisy_end_ready", 32'(get_ready(0)), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: word width in bits, legal range 2..32.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 transmits bit WIDTH-1 first, 0 transmits bit 0 first.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 0: idle cycles forced after each word, legal range 0..15.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state SHALL change on its rising edge only.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port din, input, WIDTH bits: parallel word to serialize.
REQ-007 The block SHALL have port din_valid, input, 1 bit: din holds a valid word.
REQ-008 The block SHALL have port din_ready, output, 1 bit: block can accept a word this cycle.
REQ-009 The block SHALL have port x, output, 1 bit: serial bit stream, the x input of the downstream sequence detector.
REQ-010 The block SHALL have port x_valid, output, 1 bit: x carries a data bit this cycle.
REQ-011 The block SHALL have port busy, output, 1 bit: high in SHIFT or GAP, or while the hold register is full.

Function
REQ-012 A word SHALL be accepted only at a rising edge where din_valid=1, din_ready=1 and rst=0; it is then captured into a one-word hold register and hold_full is set.
REQ-013 din_ready SHALL equal ~hold_full, with no combinational path from din_valid or from the drain decision.
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT and GAP.
REQ-015 In IDLE with hold_full=1, the next edge SHALL load the shift register from the hold register, clear bit_cnt to 0 and enter SHIFT.
REQ-016 In IDLE with hold_full=0, the FSM SHALL stay in IDLE.
REQ-017 In SHIFT, x SHALL be the current head bit of the shift register and x_valid SHALL be 1; at each edge the register SHALL shift toward the head and bit_cnt SHALL increment.
REQ-018 In SHIFT at bit_cnt=WIDTH-1 with GAP_CYCLES>0, the next edge SHALL enter GAP with gap_cnt=0.
REQ-019 In SHIFT at bit_cnt=WIDTH-1 with GAP_CYCLES=0 and hold_full=1, the next edge SHALL reload from the hold register and stay in SHIFT, giving gapless back-to-back output.
REQ-020 In SHIFT at bit_cnt=WIDTH-1 with GAP_CYCLES=0 and hold_full=0, the next edge SHALL enter IDLE.
REQ-021 In GAP, x and x_valid SHALL be 0; after GAP_CYCLES cycles the FSM SHALL make the IDLE decision (REQ-015/REQ-016) on the same edge.
REQ-022 In IDLE, x and x_valid SHALL be 0.
REQ-023 Latency: a word accepted at edge N SHALL put its first bit on x during the cycle after edge N+1, and its last bit WIDTH-1 cycles later.
REQ-024 If a load drains the hold register and a new word is accepted on the same edge, hold_full SHALL remain 1 and the hold register SHALL contain the new word.
REQ-025 din SHALL be ignored whenever din_ready=0; a held word SHALL never be overwritten.
REQ-026 bit_cnt SHALL be ceil(log2(WIDTH)) bits wide and SHALL never pass WIDTH-1; gap_cnt SHALL be 4 bits wide.

Reset
REQ-027 While rst=1 at an edge, the block SHALL set state to IDLE, hold_full to 0, bit_cnt and gap_cnt to 0, and the shift and hold registers to 0.
REQ-028 Reset SHALL take priority over acceptance and shifting on the same edge.
REQ-029 After reset the outputs SHALL be x=0, x_valid=0, busy=0 and din_ready=1.
REQ-030 A reset asserted mid-word SHALL abort that word and discard the held word, with no further x_valid pulses.

Structure
REQ-031 State encoding (IDLE/SHIFT/GAP) and the legal parameter bounds SHALL be defined in a shared package byte_ser_pkg.
REQ-032 The hold register and its valid/ready logic SHALL be one sub-module, byte_ser_hold; the FSM, counters and shift register SHALL stay in the top level.

Verification
REQ-033 Defaults, din=8'h0D accepted at edge N: x SHALL be 0,0,0,0,1,1,0,1 with x_valid high for 8 cycles, starting after edge N+1; a downstream 1101 detector SHALL flag exactly once.
REQ-034 Defaults, 8'hD0 then 8'hDD offered back-to-back: x_valid SHALL stay high for 16 consecutive cycles, bits 11010000 11011101, and din_ready SHALL be low while the hold register is full.
REQ-035 GAP_CYCLES=2, two words queued: exactly 2 cycles with x_valid=0 SHALL separate the words.
REQ-036 MSB_FIRST=0, din=8'h0D: x SHALL be 1,0,1,1,0,0,0,0.
REQ-037 rst pulsed at bit 3 of 8'hFF while 8'hAA is held: the next cycle SHALL show x_valid=0 and din_ready=1, and neither word SHALL ever be emitted.
REQ-038 din_valid held high with din_ready=0 and din changing: the words SHALL be emitted in order, with no loss and no duplication.
